// File: rtl/fetch_unit_fq.sv
// fetch_unit_fq: BTB/DIRP-predicted instruction fetch with a
// checkpointed circular RAS and a registered fetch queue to dispatch.
package fetch_unit_fq_pkg;
    typedef enum logic {
        FU_DEFAULT = 1'b0,
        FU_HALT    = 1'b1
    } fetch_unit_state_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } dirp_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;
endpackage

module fetch_unit_fq
    import fetch_unit_fq_pkg::*;
#(
    parameter logic [15:0] PC_RESET_VAL  = 16'h0,
    parameter int          BTB_FRAMES    = 8,
    parameter int          BTB_TAG_WIDTH = 4,
    parameter int          RAS_DEPTH     = 8,
    parameter int          FQ_DEPTH      = 4
) (
    input  logic                         CLK,
    input  logic                         nRST,
    output logic                         DUT_error,
    input  logic                         from_pipeline_BTB_DIRP_update,
    input  logic [13:0]                  from_pipeline_BTB_DIRP_PC,
    input  logic [13:0]                  from_pipeline_BTB_target,
    input  logic                         from_pipeline_DIRP_taken,
    input  logic                         from_pipeline_take_resolved,
    input  logic [13:0]                  from_pipeline_resolved_PC,
    input  logic [$clog2(RAS_DEPTH)-1:0] from_pipeline_RAS_index,
    input  logic                         icache_hit,
    input  logic [31:0]                  icache_load,
    output logic                         icache_REN,
    output logic [31:0]                  icache_addr,
    output logic                         icache_halt,
    input  logic                         core_control_halt,
    output logic                         to_pipeline_valid,
    input  logic                         to_pipeline_ready,
    output logic [31:0]                  to_pipeline_instr,
    output logic [13:0]                  to_pipeline_PC,
    output logic [13:0]                  to_pipeline_nPC,
    output logic [$clog2(RAS_DEPTH)-1:0] to_pipeline_RAS_index,
    output fetch_unit_state_t            FU_state_out
);
    localparam int LOG_BTB = $clog2(BTB_FRAMES);
    localparam int LOG_RAS = $clog2(RAS_DEPTH);
    localparam int LOG_FQ  = $clog2(FQ_DEPTH);
    localparam int TAG_MSB = LOG_BTB + BTB_TAG_WIDTH - 1;
    localparam logic [LOG_FQ:0] FQ_FULL = (LOG_FQ + 1)'(FQ_DEPTH);

    fetch_unit_state_t state, next_state;
    logic [13:0] pc, pc_plus1, npc;
    logic        accept, enq, deq, flush;

    logic [5:0] opcode;
    logic       is_branch, is_j, is_jal, is_jr31, is_halt;

    logic [BTB_TAG_WIDTH-1:0] btb_tag    [BTB_FRAMES];
    logic [13:0]              btb_target [BTB_FRAMES];
    dirp_state_t              btb_dirp   [BTB_FRAMES];
    logic [LOG_BTB-1:0]       pred_idx, upd_idx;
    logic [BTB_TAG_WIDTH-1:0] pred_tag, upd_tag;
    logic                     pred_taken;
    dirp_state_t              upd_dirp;
    logic                     unused_upd_pc;

    logic [13:0]        ras [RAS_DEPTH];
    logic [LOG_RAS-1:0] ras_w, ras_top;

    logic [31:0]        fq_instr [FQ_DEPTH];
    logic [13:0]        fq_pc    [FQ_DEPTH];
    logic [13:0]        fq_npc   [FQ_DEPTH];
    logic [LOG_RAS-1:0] fq_ras   [FQ_DEPTH];
    logic [LOG_FQ-1:0]  fq_head, fq_tail;
    logic [LOG_FQ:0]    fq_count;

    assign flush     = from_pipeline_take_resolved;
    assign opcode    = icache_load[31:26];
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_j      = (opcode == OP_J);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jr31   = (opcode == OP_RTYPE) &&
                       (icache_load[25:21] == 5'd31) &&
                       (icache_load[5:0] == FN_JR);
    assign is_halt   = (opcode == OP_HALT);

    assign pc_plus1   = pc + 14'd1;
    assign pred_idx   = pc[LOG_BTB-1:0];
    assign pred_tag   = pc[TAG_MSB:LOG_BTB];
    assign pred_taken = (btb_tag[pred_idx] == pred_tag) &&
                        ((btb_dirp[pred_idx] == WEAK_T) ||
                         (btb_dirp[pred_idx] == STRONG_T));
    assign upd_idx       = from_pipeline_BTB_DIRP_PC[LOG_BTB-1:0];
    assign upd_tag       = from_pipeline_BTB_DIRP_PC[TAG_MSB:LOG_BTB];
    assign unused_upd_pc = ^from_pipeline_BTB_DIRP_PC;
    assign ras_top       = ras_w - LOG_RAS'(1);

    assign icache_REN  = (state == FU_DEFAULT) && (fq_count < FQ_FULL) &&
                         !core_control_halt && !flush;
    assign icache_addr = {16'h0, pc, 2'b00};
    assign accept      = icache_hit && icache_REN;
    assign enq         = accept;

    assign to_pipeline_valid     = (fq_count != '0) && !core_control_halt;
    assign deq                   = to_pipeline_valid && to_pipeline_ready && !flush;
    assign to_pipeline_instr     = fq_instr[fq_head];
    assign to_pipeline_PC        = fq_pc[fq_head];
    assign to_pipeline_nPC       = fq_npc[fq_head];
    assign to_pipeline_RAS_index = fq_ras[fq_head];
    assign FU_state_out          = state;

    // Predict the next PC from pre-decode and pick the next fetch state.
    always_comb begin
        npc        = pc_plus1;
        next_state = state;
        unique case (1'b1)
            is_branch:    npc = pred_taken ? btb_target[pred_idx] : pc_plus1;
            is_j, is_jal: npc = icache_load[13:0];
            is_jr31:      npc = ras[ras_top];
            is_halt:      npc = pc;
            default:      npc = pc_plus1;
        endcase
        if (flush)
            next_state = FU_DEFAULT;
        else if (accept && is_halt)
            next_state = FU_HALT;
    end

    // New 2-bit direction state for the entry being trained.
    always_comb begin
        upd_dirp = btb_dirp[upd_idx];
        if (btb_tag[upd_idx] != upd_tag)
            upd_dirp = from_pipeline_DIRP_taken ? WEAK_T : WEAK_NT;
        else if (from_pipeline_DIRP_taken)
            case (btb_dirp[upd_idx])
                STRONG_NT: upd_dirp = WEAK_NT;
                default:   upd_dirp = STRONG_T;
            endcase
        else
            case (btb_dirp[upd_idx])
                STRONG_T: upd_dirp = WEAK_T;
                default:  upd_dirp = STRONG_NT;
            endcase
    end

    // Fetch state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= FU_DEFAULT;
        else
            state <= next_state;
    end

    // PC and RAS pointer: restart restores, accept advances.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc    <= PC_RESET_VAL[15:2];
            ras_w <= '0;
        end else if (flush) begin
            pc    <= from_pipeline_resolved_PC;
            ras_w <= from_pipeline_RAS_index;
        end else if (accept) begin
            pc <= npc;
            if (is_jal)
                ras_w <= ras_w + LOG_RAS'(1);
            else if (is_jr31)
                ras_w <= ras_top;
        end
    end

    // RAS storage: JAL pushes its return word address.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_DEPTH; i++)
                ras[i] <= '0;
        end else if (accept && is_jal) begin
            ras[ras_w] <= pc_plus1;
        end
    end

    // BTB training from resolved branches, independent of restart.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_FRAMES; i++) begin
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_dirp[i]   <= WEAK_NT;
            end
        end else if (from_pipeline_BTB_DIRP_update) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= from_pipeline_BTB_target;
            btb_dirp[upd_idx]   <= upd_dirp;
        end
    end

    // Fetch queue: circular buffer, flushed by restart.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fq_head  <= '0;
            fq_tail  <= '0;
            fq_count <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_instr[i] <= '0;
                fq_pc[i]    <= '0;
                fq_npc[i]   <= '0;
                fq_ras[i]   <= '0;
            end
        end else if (flush) begin
            fq_head  <= '0;
            fq_tail  <= '0;
            fq_count <= '0;
        end else begin
            if (enq) begin
                fq_instr[fq_tail] <= icache_load;
                fq_pc[fq_tail]    <= pc;
                fq_npc[fq_tail]   <= npc;
                fq_ras[fq_tail]   <= ras_w;
                fq_tail           <= fq_tail + LOG_FQ'(1);
            end
            if (deq)
                fq_head <= fq_head + LOG_FQ'(1);
            case ({enq, deq})
                2'b10:   fq_count <= fq_count + (LOG_FQ + 1)'(1);
                2'b01:   fq_count <= fq_count - (LOG_FQ + 1)'(1);
                default: fq_count <= fq_count;
            endcase
        end
    end

    // Sticky I$ halt and one-cycle unexpected-response flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icache_halt <= 1'b0;
            DUT_error   <= 1'b0;
        end else begin
            icache_halt <= icache_halt | core_control_halt;
            DUT_error   <= icache_hit & ~icache_REN & ~flush;
        end
    end
endmodule

// File: tb/tb_fetch_unit_fq.sv
// tb_fetch_unit_fq: directed and random fetch traffic against a
// queue-based reference model of the fetch unit.
module tb_fetch_unit_fq;
    import fetch_unit_fq_pkg::*;

    localparam int FQD  = 4;
    localparam int BTBF = 8;
    localparam int TW   = 4;
    localparam int RASD = 8;

    localparam logic [31:0] NOP  = 32'h8C00_0000;
    localparam logic [31:0] BEQ  = 32'h1000_0003;
    localparam logic [31:0] JAL  = 32'h0C00_0030;
    localparam logic [31:0] JR31 = 32'h03E0_0008;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              DUT_error;
    logic              upd_en = 1'b0;
    logic [13:0]       upd_pc = '0;
    logic [13:0]       upd_tgt = '0;
    logic              upd_tk = 1'b0;
    logic              take = 1'b0;
    logic [13:0]       res_pc = '0;
    logic [2:0]        res_ras = '0;
    logic              hit = 1'b0;
    logic [31:0]       load = '0;
    logic              ren;
    logic [31:0]       addr;
    logic              ihalt;
    logic              chalt = 1'b0;
    logic              valid;
    logic              ready = 1'b0;
    logic [31:0]       h_instr;
    logic [13:0]       h_pc;
    logic [13:0]       h_npc;
    logic [2:0]        h_ras;
    fetch_unit_state_t fu_state;

    always #5 CLK = ~CLK;

    fetch_unit_fq #(
        .PC_RESET_VAL (16'h0040),
        .BTB_FRAMES   (BTBF),
        .BTB_TAG_WIDTH(TW),
        .RAS_DEPTH    (RASD),
        .FQ_DEPTH     (FQD)
    ) dut (
        .CLK                          (CLK),
        .nRST                         (nRST),
        .DUT_error                    (DUT_error),
        .from_pipeline_BTB_DIRP_update(upd_en),
        .from_pipeline_BTB_DIRP_PC    (upd_pc),
        .from_pipeline_BTB_target     (upd_tgt),
        .from_pipeline_DIRP_taken     (upd_tk),
        .from_pipeline_take_resolved  (take),
        .from_pipeline_resolved_PC    (res_pc),
        .from_pipeline_RAS_index      (res_ras),
        .icache_hit                   (hit),
        .icache_load                  (load),
        .icache_REN                   (ren),
        .icache_addr                  (addr),
        .icache_halt                  (ihalt),
        .core_control_halt            (chalt),
        .to_pipeline_valid            (valid),
        .to_pipeline_ready            (ready),
        .to_pipeline_instr            (h_instr),
        .to_pipeline_PC               (h_pc),
        .to_pipeline_nPC              (h_npc),
        .to_pipeline_RAS_index        (h_ras),
        .FU_state_out                 (fu_state)
    );

    typedef struct {
        logic [31:0] instr;
        int          pc;
        int          npc;
        int          ras;
    } fq_ent_t;

    int      checks = 0;
    int      failures = 0;
    int      m_pc = 'h10;
    bit      m_halt = 0;
    bit      m_ihalt = 0;
    bit      m_err = 0;
    int      m_w = 0;
    int      m_btag [BTBF];
    int      m_btgt [BTBF];
    int      m_bcnt [BTBF];
    int      m_ras [RASD];
    fq_ent_t m_q [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int r;
        logic [31:0] w;
        r = $urandom_range(0, 99);
        w = $urandom;
        if (r < 20)      w[31:26] = (r < 10) ? 6'h04 : 6'h05;
        else if (r < 30) w[31:26] = 6'h02;
        else if (r < 40) w[31:26] = 6'h03;
        else if (r < 50) w = JR31;
        else if (r < 52) w[31:26] = 6'h3F;
        else             w[31:26] = 6'h23;
        return w;
    endfunction

    task automatic idle();
        hit = 0; ready = 0; chalt = 0; take = 0; upd_en = 0;
        #1;
    endtask

    task automatic step(input bit h, input logic [31:0] ld, input bit rdy,
                        input bit ch, input bit tk, input int rpc,
                        input int rras, input bit up, input int upc,
                        input int utg, input bit utk);
        bit ren_e, val_e, acc, deq;
        int npc, idx, tag;
        logic [5:0] opc;
        fq_ent_t e;
        hit = h; load = ld; ready = rdy; chalt = ch; take = tk;
        res_pc = rpc[13:0]; res_ras = rras[2:0];
        upd_en = up; upd_pc = upc[13:0]; upd_tgt = utg[13:0]; upd_tk = utk;
        @(negedge CLK);
        ren_e = !m_halt && (m_q.size() < FQD) && !ch && !tk;
        val_e = (m_q.size() > 0) && !ch;
        check("ren", ren, ren_e);
        check("addr", addr, m_pc * 4);
        check("valid", valid, val_e);
        check("err", DUT_error, m_err);
        check("ihalt", ihalt, m_ihalt);
        check("state", fu_state, m_halt ? FU_HALT : FU_DEFAULT);
        if (val_e) begin
            check("h_instr", h_instr, m_q[0].instr);
            check("h_pc", h_pc, m_q[0].pc);
            check("h_npc", h_npc, m_q[0].npc);
            check("h_ras", h_ras, m_q[0].ras);
        end
        acc = h && ren_e;
        deq = val_e && rdy && !tk;
        opc = ld[31:26];
        npc = (m_pc + 1) % 16384;
        if (opc == 6'h04 || opc == 6'h05) begin
            idx = m_pc % BTBF;
            tag = (m_pc / BTBF) % (1 << TW);
            if (m_btag[idx] == tag && m_bcnt[idx] >= 2)
                npc = m_btgt[idx];
        end else if (opc == 6'h02 || opc == 6'h03) begin
            npc = ld[13:0];
        end else if (ld == JR31 || (opc == 0 && ld[25:21] == 31 && ld[5:0] == 8)) begin
            npc = m_ras[(m_w + RASD - 1) % RASD];
        end else if (opc == 6'h3F) begin
            npc = m_pc;
        end
        if (up) begin
            idx = upc % BTBF;
            tag = (upc / BTBF) % (1 << TW);
            m_btgt[idx] = utg;
            if (m_btag[idx] != tag) begin
                m_btag[idx] = tag;
                m_bcnt[idx] = utk ? 2 : 1;
            end else if (utk) begin
                m_bcnt[idx] = (m_bcnt[idx] == 0) ? 1 : 3;
            end else begin
                m_bcnt[idx] = (m_bcnt[idx] == 3) ? 2 : 0;
            end
        end
        m_err = h && !ren_e && !tk;
        m_ihalt = m_ihalt || ch;
        if (tk) begin
            m_q.delete();
            m_pc = rpc % 16384;
            m_halt = 0;
            m_w = rras % RASD;
        end else begin
            if (deq) void'(m_q.pop_front());
            if (acc) begin
                e.instr = ld; e.pc = m_pc; e.npc = npc; e.ras = m_w;
                m_q.push_back(e);
                if (opc == 6'h03) begin
                    m_ras[m_w] = (m_pc + 1) % 16384;
                    m_w = (m_w + 1) % RASD;
                end else if (opc == 0 && ld[25:21] == 31 && ld[5:0] == 8) begin
                    m_w = (m_w + RASD - 1) % RASD;
                end else if (opc == 6'h3F) begin
                    m_halt = 1;
                end
                m_pc = npc;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ld);
        step(1, ld, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(input int rpc, input int rras);
        step(0, NOP, 0, 0, 1, rpc, rras, 0, 0, 0, 0);
    endtask

    initial begin
        bit up, utk;
        int upc;
        for (int i = 0; i < BTBF; i++) begin
            m_btag[i] = 0; m_btgt[i] = 0; m_bcnt[i] = 1;
        end
        for (int i = 0; i < RASD; i++) m_ras[i] = 0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_addr", addr, 32'h40);
        check("rst_valid", valid, 0);
        check("rst_err", DUT_error, 0);
        check("rst_ihalt", ihalt, 0);
        check("rst_state", fu_state, FU_DEFAULT);
        @(negedge CLK);
        nRST = 1;
        @(posedge CLK);
        #1;
        check("rel_ren", ren, 1);
        check("rel_addr", addr, 32'h40);

        repeat (6) fetch(NOP);
        idle();
        check("full_ren", ren, 0);
        check("full_addr", addr, 32'h50);
        check("full_valid", valid, 1);
        repeat (5) step(0, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        redirect('h08, 0);
        repeat (2) step(0, NOP, 0, 0, 0, 0, 0, 1, 'h08, 'h20, 1);
        fetch(BEQ);
        idle();
        check("btb_npc", h_npc, 14'h20);
        check("btb_addr", addr, 32'h80);
        redirect('h48, 0);
        fetch(BEQ);
        idle();
        check("alias_npc", h_npc, 14'h49);

        redirect('h05, 0);
        fetch(JAL);
        fetch(JR31);
        idle();
        check("jal_npc", h_npc, 14'h30);
        check("jal_ras", h_ras, 0);
        check("jr_addr", addr, 32'h18);
        step(0, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("jr_npc", h_npc, 14'h06);
        check("jr_ras", h_ras, 1);

        redirect(0, 0);
        repeat (3) fetch(NOP);
        step(0, NOP, 0, 0, 1, 'h100, 2, 0, 0, 0, 0);
        idle();
        check("flush_valid", valid, 0);
        check("flush_addr", addr, 32'h400);
        fetch(JAL);
        idle();
        check("flush_ras", h_ras, 2);

        redirect('h10, 0);
        fetch(HALT);
        idle();
        check("halt_state", fu_state, FU_HALT);
        check("halt_ren", ren, 0);
        check("halt_valid", valid, 1);
        step(1, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("err_set", DUT_error, 1);
        check("drained", valid, 0);
        step(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("err_clr", DUT_error, 0);
        redirect('h20, 0);
        idle();
        check("resume_state", fu_state, FU_DEFAULT);
        check("resume_ren", ren, 1);

        for (int i = 0; i < 1500; i++) begin
            up  = ($urandom_range(0, 3) == 0);
            utk = $urandom_range(0, 1);
            upc = $urandom_range(0, 1) ? m_pc : $urandom_range(0, 127);
            step($urandom_range(0, 9) < 7, rand_instr(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 127),
                 $urandom_range(0, 7), up, upc,
                 $urandom_range(0, 16383), utk);
        end

        redirect(0, 0);
        fetch(NOP);
        step(0, NOP, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, NOP, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("chalt_ihalt", ihalt, 1);
        check("chalt_ren", ren, 0);
        check("chalt_valid", valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
